// File: rtl/vga_grid_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vga_grid_pkg: shared grid constants, types and clip helper        |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package vga_grid_pkg;

  localparam int GRID_W      = 32;
  localparam int GRID_H      = 24;
  localparam int PIXEL_COUNT = GRID_W * GRID_H;

  typedef logic [7:0] pixel_t;
  typedef logic [4:0] gx_t;
  typedef logic [4:0] gy_t;

  typedef struct packed {
    gx_t        x0;
    gy_t        y0;
    logic [5:0] w;
    logic [4:0] h;
    pixel_t     color;
  } rect_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DRAW  = 2'd2
  } engine_state_t;

  // Inclusive end coordinate of a span clipped to the grid edge; 7 bits never wrap.
  function automatic logic [6:0] clip_end(input logic [6:0] start,
                                          input logic [6:0] size,
                                          input logic [6:0] limit);
    logic [6:0] sum;
    sum = start + size;
    return ((sum > limit) ? limit : sum) - 7'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/grid_addr_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | grid_addr_gen: raster x/y counter producing linear grid address   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module grid_addr_gen #(
  parameter int GRID_W     = 32,
  parameter int ADDR_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  step,
  input  logic [4:0]            x_start,
  input  logic [4:0]            y_start,
  input  logic [4:0]            x_end,
  input  logic [4:0]            y_end,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);
  import vga_grid_pkg::*;

  gx_t x, x_lo, x_hi;
  gy_t y, y_hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x    <= '0;
      y    <= '0;
      x_lo <= '0;
      x_hi <= '0;
      y_hi <= '0;
    end else if (start) begin
      x    <= x_start;
      y    <= y_start;
      x_lo <= x_start;
      x_hi <= x_end;
      y_hi <= y_end;
    end else if (step) begin
      if (x == x_hi) begin
        x <= x_lo;
        y <= y + 5'd1;
      end else begin
        x <= x + 5'd1;
      end
    end
  end

  // Counters are flops, so the address is effectively a registered output.
  assign addr = ADDR_WIDTH'(y) * ADDR_WIDTH'(GRID_W) + ADDR_WIDTH'(x);
  assign last = (x == x_hi) && (y == y_hi);

endmodule
`default_nettype wire

// File: rtl/rect_fill_engine.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rect_fill_engine: rectangle fill / frame clear pixel writer       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module rect_fill_engine #(
  parameter int         GRID_W      = 32,
  parameter int         GRID_H      = 24,
  parameter int         ADDR_WIDTH  = 20,
  parameter logic [7:0] CLEAR_COLOR = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  clear_on_frame,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [4:0]            cmd_x0,
  input  logic [4:0]            cmd_y0,
  input  logic [5:0]            cmd_w,
  input  logic [4:0]            cmd_h,
  input  logic [7:0]            cmd_color,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [7:0]            wr_data,
  output logic                  busy,
  output logic                  op_done,
  output logic                  cmd_err
);
  import vga_grid_pkg::*;

  engine_state_t state, state_n;
  rect_cmd_t     cmd;
  logic          clear_pending;
  logic          out_of_reset;
  logic          clear_req;
  logic          accept;
  logic          cmd_ok;
  logic          gen_start;
  logic          gen_step;
  logic          gen_last;
  logic          start_clear;
  logic          done_n;
  logic          err_n;
  gx_t           xs, xe;
  gy_t           ys, ye;

  assign cmd = '{cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color};

  assign clear_req = frame_start && clear_on_frame;
  assign cmd_ready = out_of_reset && (state == ST_IDLE) && !clear_pending && !clear_req;
  assign accept    = cmd_valid && cmd_ready;
  assign cmd_ok    = (cmd.w != '0) && (cmd.h != '0) &&
                     (7'(cmd.x0) < 7'(GRID_W)) && (7'(cmd.y0) < 7'(GRID_H));
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    gen_start   = 1'b0;
    gen_step    = 1'b0;
    start_clear = 1'b0;
    done_n      = 1'b0;
    err_n       = 1'b0;
    xs          = cmd.x0;
    ys          = cmd.y0;
    xe          = gx_t'(clip_end(7'(cmd.x0), 7'(cmd.w), 7'(GRID_W)));
    ye          = gy_t'(clip_end(7'(cmd.y0), 7'(cmd.h), 7'(GRID_H)));
    case (state)
      ST_IDLE: begin
        // A pending or same-cycle clear takes priority over any command.
        if (clear_req || clear_pending) begin
          state_n     = ST_CLEAR;
          gen_start   = 1'b1;
          start_clear = 1'b1;
          xs          = '0;
          ys          = '0;
          xe          = gx_t'(GRID_W - 1);
          ye          = gy_t'(GRID_H - 1);
        end else if (accept) begin
          if (cmd_ok) begin
            state_n   = ST_DRAW;
            gen_start = 1'b1;
          end else begin
            err_n     = 1'b1;
          end
        end
      end
      ST_CLEAR, ST_DRAW: begin
        if (gen_last) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end else begin
          gen_step = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_of_reset  <= 1'b0;
      clear_pending <= 1'b0;
      wr_en         <= 1'b0;
      wr_data       <= '0;
      op_done       <= 1'b0;
      cmd_err       <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;
      wr_en        <= (state_n != ST_IDLE);
      op_done      <= done_n;
      cmd_err      <= err_n;
      if (state == ST_IDLE) begin
        if (start_clear) clear_pending <= 1'b0;
      end else if (clear_req) begin
        clear_pending <= 1'b1;
      end
      if (gen_start) wr_data <= start_clear ? CLEAR_COLOR : cmd.color;
    end
  end

  grid_addr_gen #(
    .GRID_W     (GRID_W),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .start   (gen_start),
    .step    (gen_step),
    .x_start (xs),
    .y_start (ys),
    .x_end   (xe),
    .y_end   (ye),
    .addr    (wr_addr),
    .last    (gen_last)
  );

endmodule
`default_nettype wire

// File: tb/tb_rect_fill_engine.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_rect_fill_engine: scoreboard bench for rect_fill_engine        |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_rect_fill_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        clear_on_frame = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [4:0]  cmd_x0 = '0;
  logic [4:0]  cmd_y0 = '0;
  logic [5:0]  cmd_w = '0;
  logic [4:0]  cmd_h = '0;
  logic [7:0]  cmd_color = '0;
  logic        wr_en;
  logic [19:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        op_done;
  logic        cmd_err;

  rect_fill_engine dut (
    .clk            (clk),
    .rst            (rst),
    .frame_start    (frame_start),
    .clear_on_frame (clear_on_frame),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_x0         (cmd_x0),
    .cmd_y0         (cmd_y0),
    .cmd_w          (cmd_w),
    .cmd_h          (cmd_h),
    .cmd_color      (cmd_color),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .busy           (busy),
    .op_done        (op_done),
    .cmd_err        (cmd_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int K_WR   = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int kind;
    int addr;
    int data;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act == want) passed++;
    else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d",
                  name, act, act, want, want, cyc);
  endtask

  function automatic void push(input int k, input int a, input int d, input int c);
    exp_t e;
    e.kind = k; e.addr = a; e.data = d; e.cyc = c;
    sb.push_back(e);
  endfunction

  function automatic void push_clear(input int first, input int n);
    for (int i = 0; i < n; i++) push(K_WR, i, 'h00, first + i);
  endfunction

  task automatic pop_cmp(input int kind, input int addr, input int data);
    exp_t e;
    chk("output_expected", int'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.cyc);
      if (kind == K_WR) begin
        chk("wr_addr", addr, e.addr);
        chk("wr_data", data, e.data);
      end
    end
  endtask

  // Monitor: every DUT output event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en === 1'b1) begin
        chk("busy_during_wr", int'(busy), 1);
        chk("ready_during_wr", int'(cmd_ready), 0);
        pop_cmp(K_WR, int'(wr_addr), int'(wr_data));
      end
      if (op_done === 1'b1) begin
        chk("done_wr_en", int'(wr_en), 0);
        chk("done_busy", int'(busy), 0);
        pop_cmp(K_DONE, 0, 0);
      end
      if (cmd_err === 1'b1) pop_cmp(K_ERR, 0, 0);
    end
  end

  task automatic issue(input int x0, input int y0, input int w, input int h,
                       input int color, output int acc);
    cmd_x0    = 5'(x0);
    cmd_y0    = 5'(y0);
    cmd_w     = 6'(w);
    cmd_h     = 5'(h);
    cmd_color = 8'(color);
    cmd_valid = 1'b1;
    acc       = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin
        acc = cyc;
        break;
      end
    end
    chk("accept_in_time", int'(acc >= 0), 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    chk("scoreboard_drained", sb.size(), 0);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int n;
    int f;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_reset", int'(cmd_ready), 1);
    @(posedge clk);
    #1;

    // Small in-grid rectangle.
    issue(3, 4, 2, 2, 'h5A, n);
    push(K_WR, 131, 'h5A, n + 1);
    push(K_WR, 132, 'h5A, n + 2);
    push(K_WR, 163, 'h5A, n + 3);
    push(K_WR, 164, 'h5A, n + 4);
    push(K_DONE, 0, 0, n + 5);
    wait_drain(100);

    // Bottom-right corner, clipped to 2x2.
    issue(30, 22, 4, 4, 'hC3, n);
    push(K_WR, 734, 'hC3, n + 1);
    push(K_WR, 735, 'hC3, n + 2);
    push(K_WR, 766, 'hC3, n + 3);
    push(K_WR, 767, 'hC3, n + 4);
    push(K_DONE, 0, 0, n + 5);
    wait_drain(100);

    // Reset while idle with non-zero write registers.
    rst = 1'b1;
    #2;
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_op_done", int'(op_done), 0);
    chk("rst_cmd_err", int'(cmd_err), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_rst2", int'(cmd_ready), 1);
    @(posedge clk);
    #1;

    // Invalid commands: y0 off-grid, zero width.
    issue(0, 24, 1, 1, 'h11, n);
    push(K_ERR, 0, 0, n + 1);
    @(negedge clk);
    chk("ready_after_err", int'(cmd_ready), 1);
    wait_drain(100);
    issue(5, 5, 0, 3, 'h22, n);
    push(K_ERR, 0, 0, n + 1);
    wait_drain(100);

    // Clear requested in the same cycle as a valid command.
    f = cyc;
    frame_start    = 1'b1;
    clear_on_frame = 1'b1;
    push_clear(f + 1, 768);
    push(K_DONE, 0, 0, f + 769);
    fork
      begin
        @(posedge clk);
        #1 frame_start = 1'b0;
      end
    join_none
    issue(1, 1, 1, 1, 'h77, n);
    chk("accept_after_clear", n, f + 769);
    push(K_WR, 33, 'h77, n + 1);
    push(K_DONE, 0, 0, n + 2);
    wait_drain(1000);

    // frame_start (twice) during an 8x8 draw: one deferred clear.
    issue(8, 8, 8, 8, 'hA5, n);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        push(K_WR, (8 + r) * 32 + 8 + c, 'hA5, n + 1 + r * 8 + c);
    push(K_DONE, 0, 0, n + 65);
    push_clear(n + 66, 768);
    push(K_DONE, 0, 0, n + 834);
    step_to(n + 10);
    frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
    step_to(n + 20);
    frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
    wait_drain(2000);

    // Reset in the middle of a clear: no further writes afterwards.
    f = cyc;
    frame_start = 1'b1;
    push_clear(f + 1, 99);
    @(posedge clk);
    #1 frame_start = 1'b0;
    step_to(f + 100);
    rst = 1'b1;
    #1;
    chk("abort_wr_en", int'(wr_en), 0);
    chk("abort_busy", int'(busy), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (900) @(posedge clk);
    #1;
    chk("no_resume", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
